// File: rtl/sad_min_tracker.sv
// Motion-search SAD tracker: accumulates SAD for two candidates per pair and
// keeps the lowest SAD and its candidate index across the whole search.
module sad_min_tracker #(
  parameter int BLK_PIX   = 256,
  parameter int NUM_PAIRS = 8,
  parameter int SAD_W     = 16,
  parameter int IDX_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pix_valid,
  input  logic [7:0]       c,
  input  logic [7:0]       p,
  input  logic [7:0]       p_prime,
  output logic             busy,
  output logic             done,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx
);

  localparam int PIX_W  = (BLK_PIX > 1) ? $clog2(BLK_PIX) : 1;
  localparam int PAIR_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(BLK_PIX - 1);
  localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'(NUM_PAIRS - 1);

  // IDLE: wait for start | ACCUM: sum |c-p| | COMPARE: update best | DONE: pulse done
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_COMPARE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [SAD_W-1:0]   sad0_q, sad0_d, sad1_q, sad1_d;
  logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [PAIR_W-1:0]  pair_cnt_q, pair_cnt_d;
  logic [SAD_W-1:0]   best_sad_q, best_sad_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic [SAD_W-1:0]   cmp_sad;
  logic [IDX_W-1:0]   cmp_idx;
  logic [IDX_W-1:0]   idx_even;

  function automatic logic [SAD_W-1:0] sat_add(input logic [SAD_W-1:0] acc,
                                                input logic [7:0] x,
                                                input logic [7:0] y);
    logic [8:0]     ad;
    logic [SAD_W:0] sum;
    ad  = (x >= y) ? ({1'b0, x} - {1'b0, y}) : ({1'b0, y} - {1'b0, x});
    sum = {1'b0, acc} + {{(SAD_W - 8){1'b0}}, ad};
    return sum[SAD_W] ? {SAD_W{1'b1}} : sum[SAD_W-1:0];
  endfunction

  assign idx_even = IDX_W'({pair_cnt_q, 1'b0});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sad0_q     <= '0;
      sad1_q     <= '0;
      pix_cnt_q  <= '0;
      pair_cnt_q <= '0;
      best_sad_q <= '1;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      sad0_q     <= sad0_d;
      sad1_q     <= sad1_d;
      pix_cnt_q  <= pix_cnt_d;
      pair_cnt_q <= pair_cnt_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sad0_d     = sad0_q;
    sad1_d     = sad1_q;
    pix_cnt_d  = pix_cnt_q;
    pair_cnt_d = pair_cnt_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    cmp_sad    = best_sad_q;
    cmp_idx    = best_idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ACCUM;
          sad0_d     = '0;
          sad1_d     = '0;
          pix_cnt_d  = '0;
          pair_cnt_d = '0;
          best_sad_d = '1;
          best_idx_d = '0;
        end
      end
      S_ACCUM: begin
        if (pix_valid) begin
          sad0_d = sat_add(sad0_q, c, p);
          sad1_d = sat_add(sad1_q, c, p_prime);
          if (pix_cnt_q == PIX_LAST) begin
            pix_cnt_d = '0;
            state_d   = S_COMPARE;
          end else begin
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
          end
        end
      end
      S_COMPARE: begin
        // Even candidate first so a tie with the odd one keeps the lower index
        if (sad0_q < cmp_sad) begin
          cmp_sad = sad0_q;
          cmp_idx = idx_even;
        end
        if (sad1_q < cmp_sad) begin
          cmp_sad = sad1_q;
          cmp_idx = idx_even | IDX_W'(1);
        end
        best_sad_d = cmp_sad;
        best_idx_d = cmp_idx;
        if (pair_cnt_q == PAIR_LAST) begin
          state_d = S_DONE;
        end else begin
          pair_cnt_d = pair_cnt_q + PAIR_W'(1);
          sad0_d     = '0;
          sad1_d     = '0;
          state_d    = S_ACCUM;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign best_sad = best_sad_q;
  assign best_idx = best_idx_q;

endmodule

// File: tb/tb_sad_min_tracker.sv
// Scoreboard bench: two trackers (16-bit and 12-bit SAD) share the stimulus;
// a per-candidate SAD model predicts the winner and the done cycle.
module tb_sad_min_tracker;
  localparam int NP = 8;
  localparam int NC = 2 * NP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, pix_valid;
  logic [7:0]  c, p, pp;
  logic        busy16, done16, busy12, done12;
  logic [15:0] bs16;
  logic [11:0] bs12;
  logic [7:0]  bi16, bi12;

  sad_min_tracker #(.BLK_PIX(256), .NUM_PAIRS(NP), .SAD_W(16), .IDX_W(8)) u16 (
    .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid),
    .c(c), .p(p), .p_prime(pp), .busy(busy16), .done(done16),
    .best_sad(bs16), .best_idx(bi16));

  sad_min_tracker #(.BLK_PIX(256), .NUM_PAIRS(NP), .SAD_W(12), .IDX_W(8)) u12 (
    .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid),
    .c(c), .p(p), .p_prime(pp), .busy(busy12), .done(done12),
    .best_sad(bs12), .best_idx(bi12));

  typedef struct {
    longint dcyc;
    int     s16;
    int     i16;
    int     s12;
    int     i12;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint drv_cyc;
  int     tot[NC];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] cc, input logic [7:0] pc,
                      input logic [7:0] ppc, input logic st);
    pix_valid = v; c = cc; p = pc; pp = ppc; start = st;
    drv_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic garbage(input logic v, input logic st);
    step(v, 8'($urandom), 8'($urandom), 8'($urandom), st);
  endtask

  // Winner over all candidates for a given accumulator width: saturated totals,
  // strict less-than scan in index order so ties keep the earliest candidate.
  task automatic best_of(input int w, output int s, output int i);
    int lim;
    int v;
    lim = (1 << w) - 1;
    s = lim + 1;
    i = 0;
    for (int k = 0; k < NC; k++) begin
      v = (tot[k] > lim) ? lim : tot[k];
      if (v < s) begin
        s = v;
        i = k;
      end
    end
  endtask

  task automatic gen(input int mode, input int pr, output logic [7:0] cc,
                     output logic [7:0] pc, output logic [7:0] ppc);
    int b;
    case (mode)
      0: begin cc = 8'd100; pc = 8'd100; ppc = 8'd101; end
      1: begin
        b = $urandom_range(0, 240);
        cc = 8'(b);
        if (pr == 3) begin pc = 8'(b + 2); ppc = 8'(b + 1); end
        else begin pc = 8'(b + 5); ppc = 8'(b + 5); end
      end
      2: begin cc = 8'd255; pc = 8'd0; ppc = 8'd0; end
      4: begin
        b = $urandom_range(3, 250);
        cc = 8'(b);
        pc = 8'(b + $urandom_range(0, 2));
        ppc = 8'(b - $urandom_range(0, 2));
      end
      5: begin cc = 8'd7; pc = 8'd7; ppc = 8'd7; end
      default: begin cc = 8'($urandom); pc = 8'($urandom); ppc = 8'($urandom); end
    endcase
  endtask

  // stall: 0 none, 1 toggle valid every cycle, 2 random gaps; abort resets at pair 2 pixel 100
  task automatic run_search(input int mode, input int stall, input bit abort);
    logic [7:0] cc, pc, ppc;
    int pix, n, e16, i16, e12, i12;
    bit v, aborted;
    exp_t e;
    aborted = 0;
    for (int k = 0; k < NC; k++) tot[k] = 0;
    garbage(1'b0, 1'b1);
    chk("busy_after_start", {63'd0, busy16}, 64'd1);
    for (int pr = 0; pr < NP && !aborted; pr++) begin
      pix = 0;
      n = 0;
      while (pix < 256 && !aborted) begin
        v = (stall == 0) ? 1'b1 : (stall == 1) ? (n % 2 == 0) : ($urandom_range(0, 3) != 0);
        if (v) begin
          gen(mode, pr, cc, pc, ppc);
          if (abort && pr == 2 && pix == 100) begin
            reset = 1'b1;
            step(1'b1, cc, pc, ppc, 1'b1);
            reset = 1'b0;
            aborted = 1;
          end else begin
            tot[2*pr]   += (cc > pc)  ? int'(cc) - int'(pc)  : int'(pc) - int'(cc);
            tot[2*pr+1] += (cc > ppc) ? int'(cc) - int'(ppc) : int'(ppc) - int'(cc);
            step(1'b1, cc, pc, ppc, (pr == 0 && pix == 10));
            pix++;
          end
        end else begin
          garbage(1'b0, 1'b0);
        end
        n++;
      end
      if (!aborted) begin
        if (pr == NP - 1) begin
          best_of(16, e16, i16);
          best_of(12, e12, i12);
          e.dcyc = drv_cyc + 2;
          e.s16 = e16; e.i16 = i16; e.s12 = e12; e.i12 = i12;
          sb.push_back(e);
        end
        garbage(1'b1, 1'b0);
      end
    end
    if (aborted) begin
      chk("abort_busy", {63'd0, busy16}, 64'd0);
      chk("abort_done", {63'd0, done16}, 64'd0);
      chk("abort_sad16", {48'd0, bs16}, 64'hFFFF);
      chk("abort_sad12", {52'd0, bs12}, 64'hFFF);
      chk("abort_idx16", {56'd0, bi16}, 64'd0);
      repeat (6) garbage(1'b1, 1'b0);
    end else begin
      garbage(1'b1, 1'b1);
      chk("start_in_done_ignored", {62'd0, busy16, busy12}, 64'd0);
      repeat (3) garbage(1'b1, 1'b0);
      chk("hold_sad16", {48'd0, bs16}, 64'(e16));
      chk("hold_idx16", {56'd0, bi16}, 64'(i16));
      chk("hold_sad12", {52'd0, bs12}, 64'(e12));
      chk("hold_idx12", {56'd0, bi12}, 64'(i12));
    end
  endtask

  always @(negedge clk) begin
    if (done16 === 1'b1 || done12 === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done16=%0d done12=%0d with no search pending", done16, done12);
      end else begin
        e = sb.pop_front();
        chk("done16", {63'd0, done16}, 64'd1);
        chk("done12", {63'd0, done12}, 64'd1);
        chk("done_cycle", 64'(cyc), 64'(e.dcyc));
        chk("best_sad16", {48'd0, bs16}, 64'(e.s16));
        chk("best_idx16", {56'd0, bi16}, 64'(e.i16));
        chk("best_sad12", {52'd0, bs12}, 64'(e.s12));
        chk("best_idx12", {56'd0, bi12}, 64'(e.i12));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cnt;
    reset = 1'b1; start = 1'b0; pix_valid = 1'b0; c = 8'd0; p = 8'd0; pp = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {62'd0, busy16, busy12}, 64'd0);
    chk("rst_done", {62'd0, done16, done12}, 64'd0);
    chk("rst_sad16", {48'd0, bs16}, 64'hFFFF);
    chk("rst_sad12", {52'd0, bs12}, 64'hFFF);
    chk("rst_idx", {48'd0, bi16, bi12}, 64'd0);
    reset = 1'b0;
    garbage(1'b1, 1'b0);
    chk("idle_ignores_pix", {62'd0, busy16, busy12}, 64'd0);

    run_search(0, 0, 0);
    run_search(0, 1, 0);
    run_search(1, 0, 0);
    run_search(2, 0, 0);
    run_search(3, 2, 0);
    run_search(4, 2, 0);
    run_search(3, 0, 1);
    run_search(5, 0, 0);

    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 20) begin
      garbage(1'b0, 1'b0);
      wait_cnt++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sad_min_tracker.md
SAD_MIN_TRACKER -- requirements
Module: sad_min_tracker

Interface
REQ-001 Parameter BLK_PIX, default 256: pixel samples per candidate block (16x16).
REQ-002 Parameter NUM_PAIRS, default 8: candidate pairs per search; each pair is one p and one p_prime candidate.
REQ-003 Parameter SAD_W, default 16: accumulator and best_sad width.
REQ-004 Parameter IDX_W, default 8: candidate index width; IDX_W SHALL be large enough to hold 2*NUM_PAIRS-1.
REQ-005 Port clk, input, 1: clock; all state changes on rising edge.
REQ-006 Port reset, input, 1: reset, synchronous, active-high.
REQ-007 Port start, input, 1: one-cycle pulse from the fetch/control stage that begins a search.
REQ-008 Port pix_valid, input, 1: c, p and p_prime are valid this cycle.
REQ-009 Port c, input, 8: current-block pixel.
REQ-010 Port p, input, 8: reference pixel, even candidate (index 2k).
REQ-011 Port p_prime, input, 8: reference pixel, odd candidate (index 2k+1).
REQ-012 Port busy, output, 1: high in every state except IDLE.
REQ-013 Port done, output, 1: one-cycle pulse when the search result is final.
REQ-014 Port best_sad, output, SAD_W: lowest SAD found so far.
REQ-015 Port best_idx, output, IDX_W: candidate index of best_sad.

Function
REQ-016 FSM states: IDLE, ACCUM, COMPARE, DONE; registered state, no combinational path from inputs to outputs.
REQ-017 IDLE: start=1 -> ACCUM next cycle; clear sad0, sad1, pix_cnt and pair_cnt; set best_sad to all-ones and best_idx to 0.
REQ-018 ACCUM, pix_valid=1: sad0 += |c-p| and sad1 += |c-p_prime|, 9-bit unsigned absolute difference, zero-extended; pix_cnt increments.
REQ-019 Accumulators SHALL saturate at 2^SAD_W-1 and never wrap.
REQ-020 ACCUM, pix_valid=0: accumulators and pix_cnt hold; a stall of any length is allowed.
REQ-021 ACCUM, pix_valid=1 and pix_cnt==BLK_PIX-1: the sample is accumulated, then go to COMPARE; pix_cnt wraps to 0.
REQ-022 COMPARE, one cycle, even candidate first:
- if sad0 < best_sad, then best <= (sad0, 2*pair_cnt);
- then, against the possibly updated best, if sad1 < best, then best <= (sad1, 2*pair_cnt+1).
REQ-023 Ties SHALL keep the lower (earlier) index; comparison is strict less-than.
REQ-024 COMPARE exit: if pair_cnt==NUM_PAIRS-1, go to DONE; otherwise pair_cnt++, sad0 and sad1 clear, go to ACCUM.
REQ-025 pix_valid during COMPARE, DONE or IDLE SHALL be ignored; no sample is accumulated.
REQ-026 DONE, one cycle: done=1, best_sad and best_idx final; next state IDLE.
REQ-027 Latency: final valid sample at cycle T -> COMPARE at T+1 -> done=1 at T+2.
REQ-028 best_sad and best_idx SHALL hold after DONE until the next accepted start.
REQ-029 start while busy=1 SHALL be ignored; start in the same cycle as DONE is also ignored.
REQ-030 done SHALL be 0 in every state except DONE.

Reset
REQ-031 reset=1 SHALL force, at the next edge: state IDLE, busy=0, done=0, best_sad all-ones, best_idx 0, and all counters and accumulators cleared.
REQ-032 reset SHALL take priority over start and pix_valid, including mid-search.
REQ-033 After a mid-search reset, done SHALL NOT be asserted until a new start completes.

Verification
REQ-034 Default parameters; start; 256 valid cycles per pair with c=100, p=100, p_prime=101 for all pairs -> done 2 cycles after the final sample, best_sad=0, best_idx=0.
REQ-035 Default parameters; pair 3 uses p=c+2 and p_prime=c+1, every other candidate differs from c by 5 -> best_sad=256, best_idx=7.
REQ-036 Default parameters, SAD_W=16; c=255, p=0, p_prime=0 for all pairs -> 256*255=65280, no saturation, best_sad=65280, best_idx=0 (tie keeps lower index).
REQ-037 SAD_W=12; c=255, p=0 for all candidates -> accumulators saturate at 4095, best_sad=4095, best_idx=0.
REQ-038 pix_valid toggles 1/0 every cycle across a full search -> result identical to the unstalled run, done delayed by the stall count.
REQ-039 reset asserted at pixel 100 of pair 2, then a new start with c=p=p_prime=7 -> no done before the new search, then best_sad=0, best_idx=0.
